// File: rtl/me_search_if.sv
// me_search_if: pixel-in / motion-vector-out handshake bundle for me_search_param
interface me_search_if #(parameter int DW = 8, parameter int SW = 12, parameter int MVW = 3);
  logic block_valid, area_valid, in_ready;
  logic [DW-1:0] in_data;
  logic out_valid, out_ready, err;
  logic signed [MVW-1:0] mv_x, mv_y;
  logic [SW-1:0] out_sad;
  modport master(output block_valid, area_valid, in_data, out_ready,
                 input in_ready, out_valid, mv_x, mv_y, out_sad, err);
  modport slave(input block_valid, area_valid, in_data, out_ready,
                output in_ready, out_valid, mv_x, mv_y, out_sad, err);
endinterface

// File: rtl/me_search_param.sv
// me_search_param: full-search SAD motion estimator over a (2SR+1)^2 offset window
module me_search_param #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int SR = 2
) (
  input logic clk,
  input logic rst,
  me_search_if.slave bus
);
  localparam int W   = N + 2 * SR;
  localparam int SW  = DW + $clog2(N * N);
  localparam int MVW = $clog2(SR + 1) + 1;
  localparam int NB  = N * N;
  localparam int NA  = W * W;
  localparam int CW  = $clog2(2 * SR + 1);
  localparam int RW  = $clog2(N);
  localparam int AW  = $clog2(NA);
  localparam int BW  = $clog2(NB);
  localparam int CL  = 2 * SR;
  typedef enum logic [2:0] {IDLE, LOAD_BLK, LOAD_AREA, SEARCH, DONE} state_t;
  state_t st, nst;
  logic [DW-1:0] blk [NB];
  logic [DW-1:0] area [NA];
  logic [AW-1:0] cnt;
  logic [CW-1:0] cx, cy;
  logic [RW-1:0] row;
  logic [SW-1:0] acc, rs, cand, sad_r;
  logic signed [MVW-1:0] bx, by;
  logic blk_loaded, bad, bwr, awr, last_blk, last_area, last_row, last_cand, take;

  function automatic logic [DW-1:0] absd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a > b ? a - b : b - a;
  endfunction

  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= nst;

  always_comb begin
    nst = st;
    case (st)
      IDLE:      nst = bwr ? LOAD_BLK : awr ? LOAD_AREA : IDLE;
      LOAD_BLK:  nst = bad || (bwr && last_blk) ? IDLE : LOAD_BLK;
      LOAD_AREA: nst = bad ? IDLE : awr && last_area ? SEARCH : LOAD_AREA;
      SEARCH:    nst = last_row && last_cand ? DONE : SEARCH;
      DONE:      nst = bus.out_ready ? IDLE : DONE;
      default:   nst = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = st == IDLE || st == LOAD_BLK || st == LOAD_AREA;
    bus.out_valid = st == DONE;
    bus.err       = bad;
    bus.mv_x      = bx;
    bus.mv_y      = by;
    bus.out_sad   = sad_r;
  end

  always_comb begin
    bad = bus.in_ready && ((bus.block_valid && bus.area_valid) ||
          (st == IDLE && bus.area_valid && !blk_loaded) ||
          (st == LOAD_BLK && bus.area_valid) || (st == LOAD_AREA && bus.block_valid));
    bwr = bus.in_ready && bus.block_valid && !bad;
    awr = bus.in_ready && bus.area_valid && !bad;
    last_blk  = cnt == AW'(NB - 1);
    last_area = cnt == AW'(NA - 1);
    last_row  = row == RW'(N - 1);
    last_cand = cx == CW'(CL) && cy == CW'(CL);
    rs = '0;
    for (int j = 0; j < N; j++)
      rs = rs + SW'(absd(blk[BW'(int'(row) * N + j)],
                         area[AW'((int'(cy) + int'(row)) * W + int'(cx) + j)]));
    cand = acc + rs;
    take = (cx == '0 && cy == '0) || cand < sad_r;
  end

  always_ff @(posedge clk) begin
    if (bwr) blk[cnt[BW-1:0]] <= bus.in_data;
    if (awr) area[cnt] <= bus.in_data;
  end

  // cnt is zero whenever the FSM sits in IDLE, so it doubles as the write index for pixel 0
  always_ff @(posedge clk)
    if (rst) begin
      blk_loaded <= 1'b0;
      cnt <= '0;
      {cx, cy, row, acc} <= '0;
      {bx, by, sad_r} <= '0;
    end else begin
      cnt <= (nst == IDLE || nst == SEARCH) ? '0 : (bwr || awr) ? cnt + 1'b1 : cnt;
      blk_loaded <= bad ? 1'b0 : bwr ? (st == LOAD_BLK && last_blk) : blk_loaded;
      if (st == SEARCH) begin
        row <= last_row ? '0 : row + 1'b1;
        acc <= last_row ? '0 : cand;
        if (last_row) begin
          cx <= cx == CW'(CL) ? '0 : cx + 1'b1;
          cy <= cx == CW'(CL) ? cy + 1'b1 : cy;
          if (take) begin
            bx <= MVW'(cx) - MVW'(SR);
            by <= MVW'(SR) - MVW'(cy);
            sad_r <= cand;
          end
        end
      end else begin
        {cx, cy, row, acc} <= '0;
      end
    end
endmodule

// File: tb/tb_me_search_param.sv
// tb_me_search_param: directed vectors with a queue scoreboard and decoupled result monitor
module tb_me_search_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  me_search_if bus();
  me_search_param dut(.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_last = -1000;
  logic [17:0] exp_q[$];
  logic [7:0] blk_px[16];
  logic [7:0] area_px[64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] pk(int x, int y, int s);
    return {3'(x), 3'(y), 12'(s)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic a, input logic [7:0] d, output logic e);
    bus.block_valid = b;
    bus.area_valid = a;
    bus.in_data = d;
    @(negedge clk);
    e = bus.err;
    @(posedge clk);
    #1;
    bus.block_valid = 1'b0;
    bus.area_valid = 1'b0;
  endtask

  task automatic send_block();
    int n = 0;
    logic e;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, blk_px[i], e);
      n += int'(e);
    end
    chk("block_load_err", n, 0);
  endtask

  task automatic send_area();
    int n = 0;
    logic e;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) t_last = cyc;
      drive(1'b0, 1'b1, area_px[i], e);
      n += int'(e);
    end
    chk("area_load_err", n, 0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", 32'(bus.out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pv = 1'b0;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !pv) chk("latency", cyc - t_last, 101);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", {bus.mv_x, bus.mv_y, bus.out_sad});
        end else begin
          e = exp_q.pop_front();
          chk("result", {bus.mv_x, bus.mv_y, bus.out_sad}, e);
        end
      end
      pv = bus.out_valid && !rst;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic e;
    bus.block_valid = 1'b0;
    bus.area_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_outputs", {bus.mv_x, bus.mv_y, bus.out_sad}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // block copy at cx=3, cy=1
    for (int i = 0; i < 16; i++) blk_px[i] = 8'(i);
    for (int i = 0; i < 64; i++) area_px[i] = 8'd255;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) area_px[(1 + r) * 8 + 3 + c] = 8'(r * 4 + c);
    exp_q.push_back(pk(1, 1, 0));
    send_block();
    send_area();
    wait_valid(200);
    @(negedge clk);
    chk("after_xfer_out_valid", 32'(bus.out_valid), 0);
    chk("after_xfer_in_ready", 32'(bus.in_ready), 1);

    // reuse of the loaded block, match at cx=2, cy=2
    for (int i = 0; i < 64; i++) area_px[i] = 8'd255;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) area_px[(2 + r) * 8 + 2 + c] = 8'(r * 4 + c);
    exp_q.push_back(pk(0, 0, 0));
    @(posedge clk);
    #1;
    send_area();
    wait_valid(200);

    // all-zero tie resolves to the first candidate
    for (int i = 0; i < 16; i++) blk_px[i] = 8'd0;
    for (int i = 0; i < 64; i++) area_px[i] = 8'd0;
    exp_q.push_back(pk(-2, 2, 0));
    send_block();
    send_area();
    wait_valid(200);

    // maximal SAD held in DONE while downstream stalls
    for (int i = 0; i < 16; i++) blk_px[i] = 8'd255;
    exp_q.push_back(pk(-2, 2, 4080));
    bus.out_ready = 1'b0;
    send_block();
    send_area();
    wait_valid(200);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 bus.area_valid = ~bus.area_valid;
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_err", 32'(bus.err), 0);
      chk("hold_outputs", {bus.mv_x, bus.mv_y, bus.out_sad}, pk(-2, 2, 4080));
    end
    @(posedge clk);
    #1;
    bus.area_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("released_out_valid", 32'(bus.out_valid), 0);

    // protocol violations
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b1, 8'd7, e);
    chk("err_area_without_block", 32'(e), 1);
    @(negedge clk);
    chk("err_pulse_ends", 32'(bus.err), 0);
    chk("err_back_idle", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'(i), e);
      chk("partial_block_err", 32'(e), 0);
    end
    drive(1'b1, 1'b1, 8'd1, e);
    chk("err_both_valid", 32'(e), 1);
    drive(1'b0, 1'b1, 8'd1, e);
    chk("err_area_after_abort", 32'(e), 1);

    // reset mid-search aborts the result
    for (int i = 0; i < 16; i++) blk_px[i] = 8'(i);
    for (int i = 0; i < 64; i++) area_px[i] = 8'd255;
    send_block();
    send_area();
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    repeat (150) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
